// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, defaults and helpers for demux1x64_seq
// Contents: state encoding, LANES/SEL_W defaults, onehot4 leaf decode.
package demux_pkg;

    localparam int LANES_DEF = 64;
    localparam int SEL_W_DEF = 6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/demux1x64_seq_if.sv
// rtl/demux1x64_seq_if.sv - handshake/lane bus of the 1-to-LANES bit distributor
// Signals: mode, start, clear, in_bit, in_valid, sel (to block);
//          in_ready, out, out_strb, ptr, busy, frame_done (from block);
//          frame_par from block only when DEMUX_FRAME_PARITY_EN is defined.
// master = producer/consumer side, slave = the distributor.
interface demux1x64_seq_if #(
    parameter int LANES = 64,
    parameter int SEL_W = 6
);
    logic             mode;
    logic             start;
    logic             clear;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [LANES-1:0] out;
    logic [LANES-1:0] out_strb;
    logic [SEL_W-1:0] ptr;
    logic             busy;
    logic             frame_done;
`ifdef DEMUX_FRAME_PARITY_EN
    logic             frame_par;

    modport master (
        output mode, start, clear, in_bit, in_valid, sel,
        input  in_ready, out, out_strb, ptr, busy, frame_done, frame_par
    );
    modport slave (
        input  mode, start, clear, in_bit, in_valid, sel,
        output in_ready, out, out_strb, ptr, busy, frame_done, frame_par
    );
`else
    modport master (
        output mode, start, clear, in_bit, in_valid, sel,
        input  in_ready, out, out_strb, ptr, busy, frame_done
    );
    modport slave (
        input  mode, start, clear, in_bit, in_valid, sel,
        output in_ready, out, out_strb, ptr, busy, frame_done
    );
`endif
endinterface

// File: rtl/demux1x4.sv
// rtl/demux1x4.sv - combinational 1-to-4 one-hot decoder with enable
// Ports: en_i enable, sel_i 2-bit select, y_o one-hot output (all zero when disabled).
module demux1x4
    import demux_pkg::*;
(
    input  logic       en_i,
    input  logic [1:0] sel_i,
    output logic [3:0] y_o
);

    assign y_o = en_i ? onehot4(sel_i) : 4'b0000;

endmodule

// File: rtl/demux1x64_seq.sv
// rtl/demux1x64_seq.sv - registered 1-to-LANES bit distributor with addressed and scan modes
// Ports: clk, rst (sync, active high), bus (demux1x64_seq_if.slave).
// Optional: DEMUX_FRAME_PARITY_EN adds bus.frame_par, XOR of the bits of the last completed scan frame.
module demux1x64_seq
    import demux_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    demux1x64_seq_if.slave bus
);

    localparam int DEPTH = SEL_W / 2;
    // All decoder outputs of every tree level, packed level after level.
    localparam int NODES = (4 ** (DEPTH + 1) - 4) / 3;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [LANES-1:0] out_q, out_d;
    logic [LANES-1:0] strb_q;
    logic             fd_q, fd_d;
    logic             acc;
    logic [SEL_W-1:0] idx;
    logic [NODES-1:0] node;
    logic [LANES-1:0] dec;

    assign bus.in_ready = ~bus.clear &
                          ((state_q == ST_IDLE & ~bus.mode) | (state_q == ST_SCAN));
    assign acc = bus.in_valid & bus.in_ready;
    assign idx = (state_q == ST_SCAN) ? ptr_q : bus.sel;

    // Decode tree: root takes the top select pair, leaves take idx[1:0].
    // Node n of level k owns lane prefix n; its output j enables prefix 4n+j.
    for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
        localparam int IN_OFF  = (4 ** k - 4) / 3;
        localparam int OUT_OFF = (4 ** (k + 1) - 4) / 3;
        for (genvar n = 0; n < 4 ** k; n++) begin : g_node
            logic en;
            if (k == 0) begin : g_root
                assign en = acc;
            end else begin : g_inner
                assign en = node[IN_OFF + n];
            end
            demux1x4 u_dec (
                .en_i  (en),
                .sel_i (idx[SEL_W-1-2*k -: 2]),
                .y_o   (node[OUT_OFF + 4*n +: 4])
            );
        end
    end

    assign dec = node[NODES-1 -: LANES];

    // clear and acc are mutually exclusive because clear drops in_ready.
    always_comb begin
        out_d = out_q;
        if (bus.clear) begin
            out_d = '0;
        end else begin
            out_d = (out_q & ~dec) | (dec & {LANES{bus.in_bit}});
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        fd_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mode && bus.start) begin
                    ptr_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (acc) begin
                    ptr_d = ptr_q + SEL_W'(1);
                    if (ptr_q == SEL_W'(LANES - 1)) begin
                        fd_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                // A restart re-arms scanning even if this accept closed a frame.
                if (bus.start) begin
                    ptr_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            out_q   <= '0;
            strb_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            strb_q  <= dec;
            fd_q    <= fd_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_strb   = strb_q;
    assign bus.ptr        = ptr_q;
    assign bus.busy       = (state_q == ST_SCAN);
    assign bus.frame_done = fd_q;

`ifdef DEMUX_FRAME_PARITY_EN
    logic par_acc_q, par_acc_d;
    logic frame_par_q, frame_par_d;
    logic scan_acc;

    assign scan_acc = acc & (state_q == ST_SCAN);

    always_comb begin
        par_acc_d   = par_acc_q;
        frame_par_d = frame_par_q;
        if (scan_acc) begin
            par_acc_d = par_acc_q ^ bus.in_bit;
        end
        if (fd_d) begin
            frame_par_d = par_acc_q ^ bus.in_bit;
            par_acc_d   = 1'b0;
        end
        // Start begins a new frame; any bit accepted with it belongs to the old one.
        if (bus.start && (state_q == ST_SCAN || bus.mode)) begin
            par_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            par_acc_q   <= 1'b0;
            frame_par_q <= 1'b0;
        end else begin
            par_acc_q   <= par_acc_d;
            frame_par_q <= frame_par_d;
        end
    end

    assign bus.frame_par = frame_par_q;
`endif

endmodule

// File: tb/tb_demux1x64_seq.sv
// tb/tb_demux1x64_seq.sv - self-checking bench for demux1x64_seq
module tb_demux1x64_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    demux1x64_seq_if #(.LANES(64), .SEL_W(6)) bus ();

    demux1x64_seq #(.LANES(64), .SEL_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_fd    = 0;

    // Reference model: lane array, scan pointer, scan flag, bits of the current frame.
    bit [63:0] m_out;
    bit [63:0] m_strb;
    int        m_ptr;
    bit        m_scan;
    bit        m_fd;
    bit        m_par;
    bit        m_known;
    bit        fq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit exp_rdy, acc, was_scan;
        int lane, ones;
        #1;
        was_scan = m_scan;
        exp_rdy  = !bus.clear && (m_scan || !bus.mode);
        if (m_known) chk("in_ready", bus.in_ready, exp_rdy);
        acc    = bus.in_valid && exp_rdy;
        m_strb = '0;
        m_fd   = 1'b0;
        if (rst) begin
            m_out = '0; m_ptr = 0; m_scan = 0; m_par = 0; fq.delete();
            m_known = 1'b1;
        end else begin
            if (bus.clear) m_out = '0;
            if (acc) begin
                lane = was_scan ? m_ptr : int'(bus.sel);
                m_out[lane]  = bus.in_bit;
                m_strb[lane] = 1'b1;
                if (was_scan) begin
                    fq.push_back(bus.in_bit);
                    if (m_ptr == 63) begin
                        ones = 0;
                        foreach (fq[i]) ones += fq[i];
                        m_par  = (ones % 2) == 1;
                        m_fd   = 1'b1;
                        m_scan = 1'b0;
                        fq.delete();
                    end
                    m_ptr = (m_ptr + 1) % 64;
                end
            end
            if (bus.start && (was_scan || bus.mode)) begin
                m_ptr = 0; m_scan = 1'b1; fq.delete();
            end
        end
        @(posedge clk);
        #1;
        if (bus.frame_done === 1'b1) n_fd++;
        chk("out", bus.out, m_out);
        chk("out_strb", bus.out_strb, m_strb);
        chk("ptr", 64'(bus.ptr), 64'(m_ptr));
        chk("busy", 64'(bus.busy), 64'(m_scan));
        chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
`ifdef DEMUX_FRAME_PARITY_EN
        chk("frame_par", 64'(bus.frame_par), 64'(m_par));
`endif
    endtask

    task automatic start_scan();
        bus.mode = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic scan_bit(input bit b);
        if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0; bus.in_bit = ~b;
            tick();
        end
        bus.in_valid = 1'b1; bus.in_bit = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] pat;

        bus.mode = 0; bus.start = 0; bus.clear = 0; bus.in_bit = 0;
        bus.in_valid = 0; bus.sel = '0;
        m_known = 1'b0;

        // Reset state.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out", bus.out, 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);

        // Addressed write to lane 37.
        bus.mode = 0; bus.sel = 6'd37; bus.in_bit = 1; bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        chk("addr_out", bus.out, 64'h1 << 37);
        chk("addr_strb", bus.out_strb, 64'h1 << 37);
        tick();
        chk("addr_strb_drop", bus.out_strb, 64'h0);

        // Random addressed writes.
        for (int i = 0; i < 40; i++) begin
            bus.sel = 6'($urandom_range(0, 63));
            bus.in_bit = 1'($urandom);
            bus.in_valid = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        bus.in_valid = 0;

        // Full scan frame with the fixed pattern.
        pat = 64'hDEAD_BEEF_0123_4567;
        n_fd = 0;
        start_scan();
        for (int i = 0; i < 64; i++) scan_bit(pat[i]);
        chk("scan_pattern", bus.out, 64'hDEAD_BEEF_0123_4567);
        chk("scan_fd_count", 64'(n_fd), 64'd1);
        chk("scan_busy_fall", 64'(bus.busy), 64'h0);

        // Restart after 10 bits; mode toggled low to show it is ignored in SCAN.
        start_scan();
        for (int i = 0; i < 10; i++) scan_bit(1'($urandom));
        bus.mode = 0; bus.start = 1; bus.in_valid = 0;
        tick();
        bus.start = 0;
        chk("restart_ptr", 64'(bus.ptr), 64'h0);
        n_fd = 0;
        for (int i = 0; i < 63; i++) scan_bit(1'($urandom));
        chk("restart_no_fd", 64'(n_fd), 64'd0);
        scan_bit(1'($urandom));
        chk("restart_fd", 64'(n_fd), 64'd1);

        // Clear priority: fill all lanes, scan 5 more, then clear with a valid bit.
        start_scan();
        for (int i = 0; i < 64; i++) scan_bit(1'b1);
        chk("ones_out", bus.out, 64'hFFFF_FFFF_FFFF_FFFF);
        start_scan();
        for (int i = 0; i < 5; i++) scan_bit(1'b1);
        bus.clear = 1; bus.in_valid = 1; bus.sel = 6'd5; bus.mode = 0; bus.in_bit = 1;
        tick();
        bus.clear = 0; bus.in_valid = 0;
        chk("clear_out", bus.out, 64'h0);
        chk("clear_strb", bus.out_strb, 64'h0);
        chk("clear_ptr", 64'(bus.ptr), 64'd5);

        // Reset mid-scan at ptr 20.
        for (int i = 0; i < 15; i++) scan_bit(1'($urandom));
        chk("pre_rst_ptr", 64'(bus.ptr), 64'd20);
        rst = 1; bus.in_valid = 1; bus.in_bit = 1;
        tick();
        rst = 0; bus.in_valid = 0;
        chk("rst_out", bus.out, 64'h0);
        chk("rst_ptr", 64'(bus.ptr), 64'h0);
        chk("rst_busy", 64'(bus.busy), 64'h0);
        n_fd = 0;
        bus.mode = 1; bus.start = 0;
        for (int i = 0; i < 80; i++) begin
            bus.in_valid = 1'($urandom); bus.in_bit = 1'($urandom);
            tick();
        end
        bus.in_valid = 0;
        chk("rst_no_fd", 64'(n_fd), 64'd0);

`ifdef DEMUX_FRAME_PARITY_EN
        // Parity: 33 ones, then all zeros.
        pat = 64'h0000_0001_FFFF_FFFF;
        start_scan();
        for (int i = 0; i < 64; i++) scan_bit(pat[i]);
        chk("par_odd", 64'(bus.frame_par), 64'd1);
        start_scan();
        for (int i = 0; i < 64; i++) scan_bit(1'b0);
        chk("par_even", 64'(bus.frame_par), 64'd0);
`endif

        // Random mixed traffic.
        for (int i = 0; i < 600; i++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.clear    = ($urandom_range(0, 15) == 0);
            bus.mode     = 1'($urandom);
            bus.start    = ($urandom_range(0, 24) == 0);
            if (m_scan && m_ptr == 63) bus.start = 1'b0;
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_bit   = 1'($urandom);
            bus.sel      = 6'($urandom_range(0, 63));
            tick();
        end
        rst = 0; bus.clear = 0; bus.start = 0; bus.in_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1x64_seq.md
Name: demux1x64_seq

Overview:
- Registered 1-to-64 bit distributor; the inverse of the 64:1 selector tree.
- Routes an accepted single-bit input to one of 64 held output lanes and issues a one-cycle lane strobe.
- Two routing modes: addressed (explicit sel) and scan (internal pointer walks lanes 0..LANES-1, then flags frame done).
- Sits at the fan-out end of the serial select datapath, feeding lane-parallel consumers.

Parameters:
- LANES, 64, number of output lanes; legal values 16 or 64 (decode-tree depth 2 or 3).
- SEL_W, 6, select/pointer width, equal to log2(LANES); 4 when LANES=16.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = addressed, 1 = scan; sampled only in IDLE.
- start  in  1  scan-mode start pulse; ignored when mode=0.
- clear  in  1  synchronous clear of all lanes.
- in_bit  in  1  data bit.
- in_valid  in  1  data valid.
- in_ready  out  1  block can accept in_bit this cycle.
- sel  in  SEL_W  target lane in addressed mode.
- out  out  LANES  held lane values.
- out_strb  out  LANES  one-hot write strobe, one cycle.
- ptr  out  SEL_W  current scan pointer.
- busy  out  1  high in SCAN.
- frame_done  out  1  one-cycle pulse when the last lane of a scan frame is written.

Behaviour:
- Reset: state=IDLE; ptr=0; out=0; out_strb=0; frame_done=0; busy=0.
- Accept condition: acc = in_valid & in_ready.
- in_ready = ~clear & ((state==IDLE & mode==0) | state==SCAN).
- FSM states: IDLE, SCAN.
  - IDLE, mode=0: on acc, out[sel] <= in_bit and out_strb <= onehot(sel) on the next edge. Latency 1 clock.
  - IDLE, mode=1, start=1: ptr <= 0, go to SCAN. No data accepted in that cycle.
  - SCAN: on acc, out[ptr] <= in_bit, out_strb <= onehot(ptr), ptr <= ptr+1.
  - SCAN, acc with ptr==LANES-1: ptr wraps to 0, frame_done pulses with the strobe, next state IDLE.
- out_strb is zero in any cycle following no accept. Unwritten lanes hold their value.
- start while in SCAN: ptr <= 0, stay in SCAN. An acc in the same cycle is written to the old ptr, then ptr restarts at 0. Lane values are not cleared.
- mode is ignored while in SCAN.
- clear: out <= 0 next edge. in_ready=0, so no accept occurs. ptr and state are unchanged, and no strobe is issued.
- rst mid-scan: immediate return to the reset values above. A partial frame produces no frame_done.
- in_valid with in_ready=0: bit is dropped; the upstream holds it.
- One-hot strobe generation uses a decode tree of 1-to-4 one-hot decoders: sel[1:0] at the leaves, sel[3:2] at the next level, sel[5:4] at the root.

Optional Feature:
- Macro DEMUX_FRAME_PARITY_EN adds output port frame_par (1 bit).
- With the macro: an XOR accumulator collects every accepted bit in SCAN. It resets to 0 on start and on rst. frame_par is registered and updates in the same cycle frame_done pulses, giving the XOR of all LANES frame bits. It holds until the next frame ends.
- Without the macro: the port, accumulator and logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg holds:
  - the state encoding constants ST_IDLE=1'b0, ST_SCAN=1'b1;
  - the LANES/SEL_W defaults;
  - the function onehot4.
- Sub-module demux1x4: combinational 1-to-4 one-hot decoder with enable. Instantiated 1+4+16 times (LANES=64) through generate loops to build the strobe/write-enable tree.
- Top level owns the FSM, ptr, out register, strobe register and the parity logic.

Test Plan:
- Addressed write: rst, then mode=0, sel=6'd37, in_bit=1, in_valid=1 for one cycle. Next cycle out[37]=1, out_strb=64'h1<<37, all other out bits 0. Following cycle out_strb=0.
- Full scan frame: mode=1, start pulse, 64 accepted bits of pattern 64'hDEAD_BEEF_0123_4567 LSB first. out equals the pattern. frame_done pulses once with the lane-63 strobe. busy falls and state returns to IDLE.
- Scan restart: after 10 accepted bits, pulse start. ptr returns to 0. Lanes 0..9 are overwritten by the next bits. frame_done arrives only after 64 further accepts.
- Clear priority: out=64'hFFFF_FFFF_FFFF_FFFF; assert clear with in_valid=1, sel=5. Checks: in_ready=0, out=0 next cycle, out_strb=0, ptr unchanged.
- Reset mid-scan: rst at ptr=20. Next cycle out=0, ptr=0, busy=0. No frame_done ever fires for that frame.
- Parity (DEMUX_FRAME_PARITY_EN): frame with exactly 33 ones gives frame_par=1 at frame_done. A following frame of all zeros gives frame_par=0.
